// File: rtl/dl_coalescing_controller.sv
// dl_coalescing_controller: serves per-core word reads with row-wide memory reads.
// Optional macro DL_BROADCAST_EN: one read also serves every pending core on the leader's row.
module dl_coalescing_controller #(
    parameter int NCORES        = 4,
    parameter int WORD_W        = 16,
    parameter int WORDS_PER_ROW = 4,
    parameter int ADDR_W        = 16
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    input  logic [NCORES-1:0]               MR,
    input  logic [NCORES*ADDR_W-1:0]        MADDR,
    input  logic [WORD_W*WORDS_PER_ROW-1:0] MEMDATA,
    input  logic                            MEMVALID,
    output logic                            MEMREAD,
    output logic [ADDR_W-1:0]               MEMADDR,
    output logic [NCORES*WORD_W-1:0]        DOUT,
    output logic [NCORES-1:0]               DVALID,
    output logic                            BUSY
);
    localparam int LW = $clog2(WORDS_PER_ROW);
    localparam int RW = ADDR_W - LW;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [NCORES-1:0]        pend_q, pend_d;
    logic [NCORES-1:0]        leader_q, leader_d;
    logic [NCORES-1:0]        dvalid_q, dvalid_d;
    logic [RW-1:0]            row_q, row_d;
    logic                     memread_q, memread_d;
    logic                     busy_q, busy_d;
    logic [ADDR_W-1:0]        memaddr_q, memaddr_d;
    logic [NCORES*WORD_W-1:0] dout_q, dout_d;
    logic                     start_s;
    logic [NCORES-1:0]        served_s;

    function automatic logic [NCORES-1:0] lowest_onehot(input logic [NCORES-1:0] v);
        logic [NCORES-1:0] r;
        r = '0;
        for (int i = NCORES - 1; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [RW-1:0] core_row(input logic [NCORES*ADDR_W-1:0] a, input int i);
        return a[i*ADDR_W+LW +: RW];
    endfunction

    function automatic logic [RW-1:0] onehot_row(input logic [NCORES*ADDR_W-1:0] a,
                                                 input logic [NCORES-1:0] oh);
        logic [RW-1:0] r;
        r = '0;
        for (int i = 0; i < NCORES; i++) begin
            if (oh[i]) begin
                r = core_row(a, i);
            end
        end
        return r;
    endfunction

    // Word index 0 is the most-significant word of the row.
    function automatic logic [WORD_W-1:0] word_sel(input logic [WORD_W*WORDS_PER_ROW-1:0] d,
                                                   input logic [LW-1:0] idx);
        logic [WORD_W-1:0] r;
        r = '0;
        for (int w = 0; w < WORDS_PER_ROW; w++) begin
            if (idx == LW'(w)) begin
                r = d[(WORDS_PER_ROW-1-w)*WORD_W +: WORD_W];
            end
        end
        return r;
    endfunction

    // Cores answered by the row currently in flight.
    always_comb begin
        served_s = leader_q;
`ifdef DL_BROADCAST_EN
        for (int i = 0; i < NCORES; i++) begin
            if (pend_q[i] && (core_row(MADDR, i) == row_q)) begin
                served_s[i] = 1'b1;
            end
        end
`endif
    end

    // Next-state and registered-output logic; the leader row is chosen on entry to ISSUE.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        leader_d  = leader_q;
        row_d     = row_q;
        memread_d = 1'b0;
        memaddr_d = memaddr_q;
        dvalid_d  = '0;
        dout_d    = dout_q;
        start_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (MR != '0) begin
                    pend_d  = MR;
                    start_s = 1'b1;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (MEMVALID) begin
                    dvalid_d = served_s;
                    for (int i = 0; i < NCORES; i++) begin
                        if (served_s[i]) begin
                            dout_d[i*WORD_W +: WORD_W] = word_sel(MEMDATA, MADDR[i*ADDR_W +: LW]);
                        end
                    end
                    state_d = DELIVER;
                end else begin
                    state_d = WAIT;
                end
            end
            DELIVER: begin
                pend_d = pend_q & ~dvalid_q;
                if (pend_d != '0) begin
                    start_s = 1'b1;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                pend_d  = '0;
                state_d = IDLE;
            end
        endcase
        if (start_s) begin
            leader_d  = lowest_onehot(pend_d);
            row_d     = onehot_row(MADDR, leader_d);
            memread_d = 1'b1;
            memaddr_d = {{LW{1'b0}}, row_d};
        end else begin
            memread_d = 1'b0;
        end
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            pend_q    <= '0;
            leader_q  <= '0;
            row_q     <= '0;
            memread_q <= 1'b0;
            memaddr_q <= '0;
            dvalid_q  <= '0;
            dout_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            leader_q  <= leader_d;
            row_q     <= row_d;
            memread_q <= memread_d;
            memaddr_q <= memaddr_d;
            dvalid_q  <= dvalid_d;
            dout_q    <= dout_d;
            busy_q    <= busy_d;
        end
    end

    assign MEMREAD = memread_q;
    assign MEMADDR = memaddr_q;
    assign DVALID  = dvalid_q;
    assign DOUT    = dout_q;
    assign BUSY    = busy_q;
endmodule

// File: tb/tb_dl_coalescing_controller.sv
// Randomized self-checking bench for dl_coalescing_controller against a queue-based read model.
module tb_dl_coalescing_controller;
    localparam int NC = 4;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [3:0]  MR;
    logic [63:0] MADDR;
    logic [63:0] MEMDATA;
    logic        MEMVALID;
    logic        MEMREAD;
    logic [15:0] MEMADDR;
    logic [63:0] DOUT;
    logic [3:0]  DVALID;
    logic        BUSY;

    int n_cmp  = 0;
    int n_fail = 0;

    bit          fixed_en = 1'b0;
    logic [63:0] fixed_data = 64'h0;
    logic [15:0] exp_dout [NC];
    logic [15:0] obs_row [$];
    logic [3:0]  obs_dv [$];
    logic [63:0] obs_dout [$];
    logic [15:0] exp_row [$];
    logic [3:0]  exp_dv [$];
    logic [63:0] exp_dq [$];
    int          first_dv_c, dv_c, mv_c, end_c;
    bit          timeout, multi;

    dl_coalescing_controller dut (
        .CLK(CLK), .RST_N(RST_N), .MR(MR), .MADDR(MADDR), .MEMDATA(MEMDATA),
        .MEMVALID(MEMVALID), .MEMREAD(MEMREAD), .MEMADDR(MEMADDR), .DOUT(DOUT),
        .DVALID(DVALID), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Memory contents: word w of a row (w = 0 is the top 16 bits).
    function automatic logic [63:0] row_data(input logic [15:0] row);
        logic [63:0] d;
        if (fixed_en) return fixed_data;
        d = 64'h0;
        for (int w = 0; w < 4; w++)
            d[(3-w)*16 +: 16] = row * 16'd7 + 16'(w) * 16'h1111 + 16'h0F0F;
        return d;
    endfunction

    function automatic logic [15:0] word_of(input logic [63:0] d, input logic [1:0] idx);
        return 16'(d >> (16 * (3 - int'(idx))));
    endfunction

    function automatic logic [63:0] pack_exp();
        return {exp_dout[3], exp_dout[2], exp_dout[1], exp_dout[0]};
    endfunction

    // Reference: list of row reads and delivered sets for one captured request mask.
    task automatic model_txn(input logic [3:0] mr, input logic [63:0] addrs);
        logic [3:0]  pend, served;
        logic [15:0] lrow, ri;
        int          leader;
        exp_row.delete(); exp_dv.delete(); exp_dq.delete();
        pend = mr;
        while (pend != 4'd0) begin
            leader = 0;
            while (!pend[leader]) leader++;
            lrow   = addrs[leader*16 +: 16] >> 2;
            served = 4'd0;
            for (int i = 0; i < NC; i++) begin
                ri = addrs[i*16 +: 16] >> 2;
`ifdef DL_BROADCAST_EN
                if (pend[i] && ri == lrow) served[i] = 1'b1;
`else
                if (i == leader) served[i] = 1'b1;
`endif
                if (served[i]) exp_dout[i] = word_of(row_data(ri), addrs[i*16 +: 2]);
            end
            exp_row.push_back(lrow);
            exp_dv.push_back(served);
            exp_dq.push_back(pack_exp());
            pend &= ~served;
        end
    endtask

    // Drive one request, act as the memory, record what the DUT does until BUSY drops.
    task automatic run_txn(input logic [3:0] mr, input logic [63:0] addrs,
                           input logic [3:0] mr_hold, input int delay);
        bit armed, prev_rd, done;
        int cnt;
        armed = 0; prev_rd = 0; done = 0; cnt = 0;
        obs_row.delete(); obs_dv.delete(); obs_dout.delete();
        first_dv_c = -1; dv_c = -1; mv_c = -1; end_c = -1; timeout = 0; multi = 0;
        @(negedge CLK); MR = mr; MADDR = addrs; MEMVALID = 1'b0;
        @(negedge CLK); MR = mr_hold;
        for (int c = 1; c <= 200 && !done; c++) begin
            if (MEMREAD) begin
                obs_row.push_back(MEMADDR);
                if (prev_rd) multi = 1;
            end
            prev_rd = MEMREAD;
            if (DVALID != 4'd0) begin
                obs_dv.push_back(DVALID);
                obs_dout.push_back(DOUT);
                dv_c = c;
                if (first_dv_c < 0) first_dv_c = c;
            end
            if (!BUSY) begin
                MR = 4'd0; MEMVALID = 1'b0; done = 1; end_c = c;
            end else begin
                if (MEMREAD) begin
                    armed = 1; cnt = delay; MEMVALID = 1'b0;
                end else if (armed && cnt == 0) begin
                    MEMVALID = 1'b1; MEMDATA = row_data(obs_row[$]); armed = 0; mv_c = c;
                end else if (armed) begin
                    cnt--; MEMVALID = 1'b0;
                end else begin
                    MEMVALID = 1'b0;
                end
                @(negedge CLK);
            end
        end
        if (!done) timeout = 1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; MR = 4'd0; MADDR = 64'h0; MEMDATA = 64'h0; MEMVALID = 1'b0;
        for (int i = 0; i < NC; i++) exp_dout[i] = 16'h0;
        repeat (2) @(negedge CLK);
        n_cmp++; if ({MEMREAD, MEMADDR, DVALID, BUSY} !== 22'h0) begin
            n_fail++; $display("FAIL reset_ctrl: got %h want 0", {MEMREAD, MEMADDR, DVALID, BUSY}); end
        n_cmp++; if (DOUT !== 64'h0) begin
            n_fail++; $display("FAIL reset_dout: got %h want 0", DOUT); end
        RST_N = 1'b1;
    endtask

    task automatic test_spec_vectors();
        logic [63:0] a;
        fixed_en = 1'b1; fixed_data = 64'hAAAA_BBBB_CCCC_DDDD;
        a = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
        run_txn(4'hF, a, 4'h0, 0);
        n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL v32_timeout: got 1 want 0"); end
        n_cmp++; if (first_dv_c !== 3) begin
            n_fail++; $display("FAIL v32_latency: got %0d want 3", first_dv_c); end
`ifdef DL_BROADCAST_EN
        n_cmp++; if (obs_row.size() !== 1 || obs_dv.size() !== 1) begin
            n_fail++; $display("FAIL v32_count: got %0d/%0d want 1/1", obs_row.size(), obs_dv.size());
        end else begin
            n_cmp++; if (obs_row[0] !== 16'h0004 || obs_dv[0] !== 4'hF) begin
                n_fail++; $display("FAIL v32_read: got %h/%h want 0004/f", obs_row[0], obs_dv[0]); end
        end
`else
        n_cmp++; if (obs_row.size() !== 4 || obs_dv.size() !== 4) begin
            n_fail++; $display("FAIL v34_count: got %0d/%0d want 4/4", obs_row.size(), obs_dv.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++; if (obs_row[k] !== 16'h0004 || obs_dv[k] !== 4'(1 << k)) begin
                    n_fail++; $display("FAIL v34_read%0d: got %h/%h want 0004/%h",
                                       k, obs_row[k], obs_dv[k], 4'(1 << k)); end
            end
        end
`endif
        n_cmp++; if (DOUT !== 64'hDDDD_CCCC_BBBB_AAAA) begin
            n_fail++; $display("FAIL v32_dout: got %h want DDDDCCCCBBBBAAAA", DOUT); end
        model_txn(4'hF, a);
        fixed_en = 1'b0;
        a = {16'h0000, 16'h0047, 16'h0000, 16'h0020};
        run_txn(4'b0101, a, 4'h0, 0);
        n_cmp++; if (obs_row.size() !== 2 || obs_dv.size() !== 2) begin
            n_fail++; $display("FAIL v33_count: got %0d/%0d want 2/2", obs_row.size(), obs_dv.size());
        end else begin
            n_cmp++; if (obs_row[0] !== 16'h0008 || obs_row[1] !== 16'h0011) begin
                n_fail++; $display("FAIL v33_rows: got %h,%h want 0008,0011", obs_row[0], obs_row[1]); end
            n_cmp++; if (obs_dv[0] !== 4'b0001 || obs_dv[1] !== 4'b0100) begin
                n_fail++; $display("FAIL v33_dv: got %b,%b want 0001,0100", obs_dv[0], obs_dv[1]); end
            n_cmp++; if (obs_dout[0][15:0] !== word_of(row_data(16'h0008), 2'd0)) begin
                n_fail++; $display("FAIL v33_lane0: got %h want %h", obs_dout[0][15:0],
                                   word_of(row_data(16'h0008), 2'd0)); end
            n_cmp++; if (obs_dout[1][47:32] !== word_of(row_data(16'h0011), 2'd3)) begin
                n_fail++; $display("FAIL v33_lane2: got %h want %h", obs_dout[1][47:32],
                                   word_of(row_data(16'h0011), 2'd3)); end
        end
        model_txn(4'b0101, a);
    endtask

    task automatic test_random();
        logic [3:0]  mr, hold;
        logic [63:0] a;
        logic [13:0] base, r;
        int          d;
        for (int t = 0; t < 30; t++) begin
            mr = 4'($urandom_range(1, 15)); hold = 4'($urandom_range(0, 15));
            base = 14'($urandom); d = $urandom_range(0, 3);
            for (int i = 0; i < NC; i++) begin
                r = ($urandom_range(0, 2) != 0) ? base : 14'($urandom);
                a[i*16 +: 16] = {r, 2'($urandom)};
            end
            run_txn(mr, a, hold, d);
            model_txn(mr, a);
            n_cmp++; if (timeout !== 1'b0 || multi !== 1'b0) begin
                n_fail++; $display("FAIL rnd%0d_proto: timeout=%0d multipulse=%0d want 0/0", t, timeout, multi); end
            n_cmp++; if (first_dv_c !== 3 + d) begin
                n_fail++; $display("FAIL rnd%0d_latency: got %0d want %0d", t, first_dv_c, 3 + d); end
            n_cmp++; if (obs_row.size() !== exp_row.size() || obs_dv.size() !== exp_dv.size()) begin
                n_fail++; $display("FAIL rnd%0d_count: got %0d/%0d want %0d/%0d", t,
                                   obs_row.size(), obs_dv.size(), exp_row.size(), exp_dv.size());
            end else begin
                for (int k = 0; k < exp_row.size(); k++) begin
                    n_cmp++; if (obs_row[k] !== exp_row[k] || obs_dv[k] !== exp_dv[k] ||
                                 obs_dout[k] !== exp_dq[k]) begin
                        n_fail++; $display("FAIL rnd%0d_step%0d: got %h/%b/%h want %h/%b/%h", t, k,
                                           obs_row[k], obs_dv[k], obs_dout[k], exp_row[k], exp_dv[k], exp_dq[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_busy_capture();
        logic [63:0] a;
        a = {16'h0300, 16'h0201, 16'h0102, 16'h0003};
        run_txn(4'b0001, a, 4'b0011, 1);
        model_txn(4'b0001, a);
        n_cmp++; if (obs_row.size() !== 1 || obs_dv.size() !== 1) begin
            n_fail++; $display("FAIL busy_count: got %0d/%0d want 1/1", obs_row.size(), obs_dv.size());
        end else begin
            n_cmp++; if (obs_dv[0] !== 4'b0001 || obs_dout[0] !== exp_dq[0]) begin
                n_fail++; $display("FAIL busy_serve: got %b/%h want 0001/%h", obs_dv[0], obs_dout[0], exp_dq[0]); end
        end
        run_txn(4'b0010, a, 4'b0000, 0);
        model_txn(4'b0010, a);
        n_cmp++; if (obs_dv.size() !== 1 || DOUT !== exp_dq[0]) begin
            n_fail++; $display("FAIL busy_next: got %0d/%h want 1/%h", obs_dv.size(), DOUT, exp_dq[0]);
        end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge CLK); MR = 4'b0001; MADDR = {48'h0, 16'h0123}; MEMVALID = 1'b0;
        @(negedge CLK); MR = 4'd0;
        n_cmp++; if (MEMREAD !== 1'b1) begin n_fail++; $display("FAIL rstw_issue: got %b want 1", MEMREAD); end
        @(negedge CLK);
        #1 RST_N = 1'b0;
        #1;
        n_cmp++; if ({MEMREAD, MEMADDR, DVALID, BUSY} !== 22'h0 || DOUT !== 64'h0) begin
            n_fail++; $display("FAIL rstw_outputs: got %h/%h want 0/0", {MEMREAD, MEMADDR, DVALID, BUSY}, DOUT); end
        @(negedge CLK); RST_N = 1'b1; MEMVALID = 1'b1; MEMDATA = 64'h1234_5678_9ABC_DEF0;
        for (int i = 0; i < NC; i++) exp_dout[i] = 16'h0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            n_cmp++; if (DVALID !== 4'd0 || BUSY !== 1'b0 || MEMREAD !== 1'b0 || DOUT !== 64'h0) begin
                n_fail++; $display("FAIL rstw_ignore%0d: got %b/%b/%b/%h want 0/0/0/0", c, DVALID, BUSY, MEMREAD, DOUT); end
        end
        MEMVALID = 1'b0;
    endtask

    task automatic test_delayed_valid();
        logic [63:0] a;
        a = {16'h0, 16'h0, 16'h0, 16'h0ABE};
        run_txn(4'b0001, a, 4'b0000, 5);
        model_txn(4'b0001, a);
        n_cmp++; if (multi !== 1'b0 || obs_row.size() !== 1) begin
            n_fail++; $display("FAIL dly_memread: multipulse=%0d reads=%0d want 0/1", multi, obs_row.size()); end
        n_cmp++; if (mv_c !== 7 || dv_c !== mv_c + 1) begin
            n_fail++; $display("FAIL dly_timing: memvalid@%0d dvalid@%0d want 7/8", mv_c, dv_c); end
        n_cmp++; if (end_c !== dv_c + 1 || DOUT !== exp_dq[0]) begin
            n_fail++; $display("FAIL dly_busy: idle@%0d dout=%h want %0d/%h", end_c, DOUT, dv_c + 1, exp_dq[0]); end
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_random();
        test_busy_capture();
        test_reset_mid_wait();
        test_delayed_valid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/dl_coalescing_controller.md
DL_COALESCING_CONTROLLER -- requirements
Module: dl_coalescing_controller

Interface
REQ-001 Parameter NCORES, default 4: number of requesting cores (range 2..8).
REQ-002 Parameter WORD_W, default 16: core data word width in bits.
REQ-003 Parameter WORDS_PER_ROW, default 4: words per memory row (power of 2, at least 2); LW = log2(WORDS_PER_ROW).
REQ-004 Parameter ADDR_W, default 16: address width in bits.
REQ-005 CLK  in  1  sole clock; all state SHALL update on its rising edge.
REQ-006 RST_N  in  1  reset, asynchronous assert, active-low.
REQ-007 MR  in  NCORES  per-core read request; bit i belongs to core i.
REQ-008 MADDR  in  NCORES*ADDR_W  per-core word address; core i occupies bits [i*ADDR_W +: ADDR_W].
REQ-009 MEMDATA  in  WORD_W*WORDS_PER_ROW  row data from data memory.
REQ-010 MEMVALID  in  1  MEMDATA is valid this cycle.
REQ-011 MEMREAD  out  1  one-cycle read strobe to data memory.
REQ-012 MEMADDR  out  ADDR_W  row address, equal to the leader address shifted right by LW and zero-extended.
REQ-013 DOUT  out  NCORES*WORD_W  per-core returned word, same packing as MADDR.
REQ-014 DVALID  out  NCORES  one-cycle per-core delivery pulse.
REQ-015 BUSY  out  1  high whenever the state is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT and DELIVER.
REQ-017 IDLE, MR != 0 at the clock edge: latch PEND = MR and go to ISSUE; MR changes SHALL NOT alter PEND until the FSM returns to IDLE.
REQ-018 ISSUE: leader = lowest-index set PEND bit; drive MEMREAD=1 and MEMADDR = leader row for exactly this one cycle; latch the row in ROW; go to WAIT.
REQ-019 WAIT: hold until MEMVALID=1, then register MEMDATA and go to DELIVER; MEMVALID SHALL be ignored in every other state.
REQ-020 DELIVER: assert DVALID for the served set for one cycle, clear those bits from PEND, then go to ISSUE if PEND != 0, else to IDLE.
REQ-021 Served set SHALL be the leader plus every PEND core whose row equals ROW (coalescing).
REQ-022 Word select SHALL use MADDR[LW-1:0]; index 0 selects the most-significant word of the row and index WORDS_PER_ROW-1 selects the least-significant word.
REQ-023 DOUT for core i SHALL update only on its delivery and SHALL hold its value otherwise.
REQ-024 Minimum latency from MR sampled (edge 0) to DVALID high SHALL be 3 cycles when MEMVALID arrives in the first WAIT cycle.
REQ-025 A core SHALL hold MADDR stable until its DVALID pulse; MR still high in IDLE SHALL be treated as a new request.
REQ-026 A core that drops MR after capture SHALL still be served.
REQ-027 Requests arriving while BUSY SHALL wait for the next IDLE capture.

Reset
REQ-028 RST_N low SHALL immediately force IDLE, PEND=0, ROW=0, MEMREAD=0, MEMADDR=0, DVALID=0, DOUT=0 and BUSY=0, including mid-transaction.
REQ-029 A MEMVALID arriving after a mid-transaction reset SHALL be ignored.

Configuration
REQ-030 Macro DL_BROADCAST_EN defined: coalescing per REQ-021 applies.
REQ-031 Macro DL_BROADCAST_EN undefined: the served set SHALL be the leader only, giving one memory read per captured core, served in ascending index order.

Verification
REQ-032 Defaults; all 4 MR=1, MADDR=0x0010,0x0011,0x0012,0x0013; MEMDATA=0xAAAA_BBBB_CCCC_DDDD -> one MEMREAD with MEMADDR=0x0004; DOUT=AAAA,BBBB,CCCC,DDDD; DVALID=0xF at cycle 3.
REQ-033 MR=0b0101 with MADDR0=0x0020 and MADDR2=0x0047 -> two reads, MEMADDR 0x0008 then 0x0011; DVALID=0b0001 then 0b0100.
REQ-034 With DL_BROADCAST_EN undefined, the REQ-032 stimulus -> four reads of 0x0004 and DVALID pulses 0x1, 0x2, 0x4, 0x8.
REQ-035 MR1 asserted while BUSY serving core 0 -> core 1 is not captured until IDLE, and PEND stays 0b0001 throughout.
REQ-036 RST_N pulsed low during WAIT, then MEMVALID=1 -> all outputs 0, FSM in IDLE, no DVALID.
REQ-037 MEMVALID delayed 5 cycles -> MEMREAD stays a single pulse, BUSY stays 1, and DVALID arrives exactly 1 cycle after MEMVALID.
